lpif_auto_sync_nch: RTL and testbench

LPIF_AUTO_SYNC_NCH -- requirements
Module: lpif_auto_sync_nch

---
 rtl/lpif_auto_sync_pkg.sv | 29 ++
 rtl/lpif_delay_cnt.sv | 37 +++
 rtl/lpif_auto_sync_nch.sv | 198 +++++++++++++++++++
 tb/tb_lpif_auto_sync_nch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_auto_sync_pkg.sv
// Shared types and constants for the LPIF auto-sync sequencer.
// State enums, debug word layout and window-length helper.
package lpif_auto_sync_pkg;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_MRK    = 2'd1,
    TX_STB    = 2'd2,
    TX_ONLINE = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_WAIT   = 2'd1,
    RX_ONLINE = 2'd2
  } rx_state_e;

  localparam int DBG_RX_MASK_LSB = 24;
  localparam int DBG_TX_ON       = 19;
  localparam int DBG_RX_ON       = 18;
  localparam int DBG_TX_ST_LSB   = 16;
  localparam int DBG_RX_ST_LSB   = 14;

  // Counter load value so that a window lasts max(v,1) cycles.
  function automatic logic [15:0] win_last(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

endpackage

// File: rtl/lpif_delay_cnt.sv
// 16-bit saturating down-counter with clear, load and enable.
// done is high whenever the count has reached zero.
module lpif_delay_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        done
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 16'd0);

endmodule

// File: rtl/lpif_auto_sync_nch.sv
// LPIF TX/RX online sequencer with marker/strobe gating.
// TX walks IDLE->MRK->STB->ONLINE; RX waits on all channels.
module lpif_auto_sync_nch
  import lpif_auto_sync_pkg::*;
#(
  parameter int unsigned NUM_CHAN          = 2,
  parameter int unsigned MARKER_WIDTH      = 1,
  parameter bit          PERSISTENT_MARKER = 1'b1,
  parameter bit          PERSISTENT_STROBE = 1'b1
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    tx_online,
  input  logic [NUM_CHAN-1:0]     rx_online,
  input  logic                    rx_online_holdoff,
  input  logic [15:0]             delay_x_value,
  input  logic [15:0]             delay_y_value,
  input  logic [15:0]             delay_z_value,
  input  logic [MARKER_WIDTH-1:0] tx_mrk_userbit,
  input  logic                    tx_stb_userbit,
  output logic                    tx_online_delay,
  output logic                    rx_online_delay,
  output logic [MARKER_WIDTH-1:0] tx_auto_mrk_userbit,
  output logic                    tx_auto_stb_userbit,
  output logic [31:0]             debug_status
);

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic        tx_clr, tx_load, tx_en, tx_done;
  logic [15:0] tx_ld_val;
  logic        rx_clr, rx_load, rx_en, rx_done;
  logic [15:0] rx_ld_val;

  logic                    tx_on_q, tx_on_d;
  logic                    rx_on_q, rx_on_d;
  logic [MARKER_WIDTH-1:0] mrk_q, mrk_d;
  logic                    stb_q, stb_d;
  logic [31:0]             debug_q, debug_d;
  logic [7:0]              rx_mask;
  logic                    rx_all;

  assign rx_all = &rx_online;

  lpif_delay_cnt u_tx_cnt (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .clr      (tx_clr),
    .load     (tx_load),
    .load_val (tx_ld_val),
    .en       (tx_en),
    .done     (tx_done)
  );

  lpif_delay_cnt u_rx_cnt (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .clr      (rx_clr),
    .load     (rx_load),
    .load_val (rx_ld_val),
    .en       (rx_en),
    .done     (rx_done)
  );

  // A tx_online drop overrides any window expiry.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_clr     = 1'b0;
    tx_load    = 1'b0;
    tx_ld_val  = '0;
    tx_en      = 1'b0;
    if (!tx_online) begin
      tx_state_d = TX_IDLE;
      tx_clr     = 1'b1;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          tx_state_d = TX_MRK;
          tx_load    = 1'b1;
          tx_ld_val  = win_last(delay_x_value);
        end
        TX_MRK: begin
          if (tx_done) begin
            tx_state_d = TX_STB;
            tx_load    = 1'b1;
            tx_ld_val  = win_last(delay_y_value);
          end else begin
            tx_en = 1'b1;
          end
        end
        TX_STB: begin
          if (tx_done) begin
            tx_state_d = TX_ONLINE;
            tx_clr     = 1'b1;
          end else begin
            tx_en = 1'b1;
          end
        end
        default: tx_state_d = TX_ONLINE;
      endcase
    end
  end

  // Holdoff freezes both the count and the exit from WAIT.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_clr     = 1'b0;
    rx_load    = 1'b0;
    rx_ld_val  = '0;
    rx_en      = 1'b0;
    if (!rx_all) begin
      rx_state_d = RX_IDLE;
      rx_clr     = 1'b1;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          rx_state_d = RX_WAIT;
          rx_load    = 1'b1;
          rx_ld_val  = win_last(delay_z_value);
        end
        RX_WAIT: begin
          if (rx_done && !rx_online_holdoff) begin
            rx_state_d = RX_ONLINE;
            rx_clr     = 1'b1;
          end else begin
            rx_en = !rx_online_holdoff;
          end
        end
        RX_ONLINE: rx_state_d = RX_ONLINE;
        default:   rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_on_d = (tx_state_q == TX_ONLINE);
    rx_on_d = (rx_state_q == RX_ONLINE);
    mrk_d   = '0;
    stb_d   = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        mrk_d = '0;
        stb_d = 1'b0;
      end
      TX_MRK: begin
        mrk_d = tx_mrk_userbit;
        stb_d = tx_stb_userbit;
      end
      TX_STB: begin
        mrk_d = PERSISTENT_MARKER ? tx_mrk_userbit : '0;
        stb_d = tx_stb_userbit;
      end
      default: begin
        mrk_d = PERSISTENT_MARKER ? tx_mrk_userbit : '0;
        stb_d = PERSISTENT_STROBE ? tx_stb_userbit : 1'b0;
      end
    endcase
  end

  always_comb begin
    rx_mask                = '0;
    rx_mask[NUM_CHAN-1:0]  = rx_online;
    debug_d                = '0;
    debug_d[DBG_RX_MASK_LSB +: 8] = rx_mask;
    debug_d[DBG_TX_ON]            = tx_on_d;
    debug_d[DBG_RX_ON]            = rx_on_d;
    debug_d[DBG_TX_ST_LSB +: 2]   = tx_state_q;
    debug_d[DBG_RX_ST_LSB +: 2]   = rx_state_q;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_on_q    <= 1'b0;
      rx_on_q    <= 1'b0;
      mrk_q      <= '0;
      stb_q      <= 1'b0;
      debug_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_on_q    <= tx_on_d;
      rx_on_q    <= rx_on_d;
      mrk_q      <= mrk_d;
      stb_q      <= stb_d;
      debug_q    <= debug_d;
    end
  end

  assign tx_online_delay     = tx_on_q;
  assign rx_online_delay     = rx_on_q;
  assign tx_auto_mrk_userbit = mrk_q;
  assign tx_auto_stb_userbit = stb_q;
  assign debug_status        = debug_q;

endmodule

// File: tb/tb_lpif_auto_sync_nch.sv
// Bench for lpif_auto_sync_nch: directed bring-up cases plus
// random traffic against a phase/elapsed-cycle reference model.
module tb_lpif_auto_sync_nch;

  localparam int NC = 4;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_online;
  logic [NC-1:0] rx_online;
  logic          holdoff;
  logic [15:0]   dx, dy, dz;
  logic [MW-1:0] mrk;
  logic          stb;

  logic          tx_on_a, rx_on_a, stb_a;
  logic [MW-1:0] mrk_a;
  logic [31:0]   dbg_a;
  logic          tx_on_b, rx_on_b, stb_b;
  logic [MW-1:0] mrk_b;
  logic [31:0]   dbg_b;

  always #5 clk = ~clk;

  lpif_auto_sync_nch #(
    .NUM_CHAN(NC), .MARKER_WIDTH(MW),
    .PERSISTENT_MARKER(1'b0), .PERSISTENT_STROBE(1'b0)
  ) dut_a (
    .clk_wr(clk), .rst_wr_n(rst_n),
    .tx_online(tx_online), .rx_online(rx_online),
    .rx_online_holdoff(holdoff),
    .delay_x_value(dx), .delay_y_value(dy), .delay_z_value(dz),
    .tx_mrk_userbit(mrk), .tx_stb_userbit(stb),
    .tx_online_delay(tx_on_a), .rx_online_delay(rx_on_a),
    .tx_auto_mrk_userbit(mrk_a), .tx_auto_stb_userbit(stb_a),
    .debug_status(dbg_a)
  );

  lpif_auto_sync_nch #(
    .NUM_CHAN(NC), .MARKER_WIDTH(MW),
    .PERSISTENT_MARKER(1'b1), .PERSISTENT_STROBE(1'b1)
  ) dut_b (
    .clk_wr(clk), .rst_wr_n(rst_n),
    .tx_online(tx_online), .rx_online(rx_online),
    .rx_online_holdoff(holdoff),
    .delay_x_value(dx), .delay_y_value(dy), .delay_z_value(dz),
    .tx_mrk_userbit(mrk), .tx_stb_userbit(stb),
    .tx_online_delay(tx_on_b), .rx_online_delay(rx_on_b),
    .tx_auto_mrk_userbit(mrk_b), .tx_auto_stb_userbit(stb_b),
    .debug_status(dbg_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: phase 0..3 (tx) / 0..2 (rx) plus elapsed counts.
  int tph, tel, tlen;
  int rph, rel, rlen;
  logic          e_tx_on, e_rx_on, e_stb_a, e_stb_b;
  logic [MW-1:0] e_mrk_a, e_mrk_b;
  logic [31:0]   e_dbg;

  function automatic int mx1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    tph = 0; tel = 0; tlen = 0;
    rph = 0; rel = 0; rlen = 0;
    e_tx_on = 0; e_rx_on = 0; e_stb_a = 0; e_stb_b = 0;
    e_mrk_a = '0; e_mrk_b = '0; e_dbg = '0;
  endtask

  task automatic model_edge();
    int otph, orph;
    logic [7:0] m8;
    if (!rst_n) begin
      model_reset();
      return;
    end
    otph = tph;
    orph = rph;
    e_tx_on = (otph == 3);
    e_rx_on = (orph == 2);
    e_mrk_a = (otph == 1) ? mrk : '0;
    e_mrk_b = (otph != 0) ? mrk : '0;
    e_stb_a = (otph == 1 || otph == 2) ? stb : 1'b0;
    e_stb_b = (otph != 0) ? stb : 1'b0;
    m8 = '0;
    m8[NC-1:0] = rx_online;
    e_dbg = {m8, 4'b0, e_tx_on, e_rx_on, 2'(otph), 2'(orph), 14'b0};
    if (!tx_online) begin
      tph = 0; tel = 0;
    end else if (tph == 0) begin
      tph = 1; tel = 0; tlen = mx1(int'(dx));
    end else if (tph == 1 || tph == 2) begin
      tel++;
      if (tel == tlen) begin
        tph++;
        tel = 0;
        tlen = mx1(int'(dy));
      end
    end
    if (!(&rx_online)) begin
      rph = 0; rel = 0;
    end else if (rph == 0) begin
      rph = 1; rel = 0; rlen = mx1(int'(dz));
    end else if (rph == 1) begin
      if (!holdoff) rel++;
      if (rel == rlen) rph = 2;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tx_on_a", tx_on_a, e_tx_on);
    check("tx_on_b", tx_on_b, e_tx_on);
    check("rx_on_a", rx_on_a, e_rx_on);
    check("rx_on_b", rx_on_b, e_rx_on);
    check("mrk_a", mrk_a, e_mrk_a);
    check("mrk_b", mrk_b, e_mrk_b);
    check("stb_a", stb_a, e_stb_a);
    check("stb_b", stb_b, e_stb_b);
    check("dbg_a", dbg_a, e_dbg);
    check("dbg_b", dbg_b, e_dbg);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_txon"}, {tx_on_a, tx_on_b}, 0);
    check({tag, "_rxon"}, {rx_on_a, rx_on_b}, 0);
    check({tag, "_mrk"}, {mrk_a, mrk_b}, 0);
    check({tag, "_stb"}, {stb_a, stb_b}, 0);
    check({tag, "_dbg"}, dbg_a | dbg_b, 0);
  endtask

  // Edge 0 is the first edge sampling tx_online high.
  task automatic tx_bringup(input int x, input int y, input string tag);
    int first;
    first = -1;
    dx = 16'(x);
    dy = 16'(y);
    tx_online = 1'b1;
    for (int k = 0; k <= x + y + 4; k++) begin
      step();
      if (tx_on_a && first < 0) first = k;
    end
    check(tag, first, mx1(x) + mx1(y) + 1);
  endtask

  task automatic rand_inputs();
    tx_online = ($urandom_range(0, 24) != 0);
    rx_online = ($urandom_range(0, 14) == 0) ? NC'($urandom) : '1;
    holdoff   = ($urandom_range(0, 2) == 0);
    dx  = 16'($urandom_range(0, 6));
    dy  = 16'($urandom_range(0, 6));
    dz  = 16'($urandom_range(0, 6));
    mrk = MW'($urandom);
    stb = 1'($urandom);
  endtask

  initial begin
    int first;
    model_reset();
    tx_online = 0; rx_online = '0; holdoff = 0;
    dx = 0; dy = 0; dz = 0; mrk = '1; stb = 1;
    repeat (3) step();
    check_zero("reset");
    #3 rst_n = 1'b1;
    step();

    tx_bringup(4, 3, "tx_lat_x4y3");
    tx_online = 0;
    step();
    step();
    tx_bringup(0, 0, "tx_lat_x0y0");

    // Drop on the last MRK cycle.
    tx_online = 0;
    step();
    dx = 2; dy = 2; tx_online = 1;
    step();
    step();
    tx_online = 0;
    step();
    step();
    check("drop_mrk_txon", {tx_on_a, mrk_a, stb_a}, 0);

    // RX wait with two holdoff cycles.
    rx_online = '0;
    step();
    dz = 5; rx_online = '1;
    step();
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      holdoff = (k == 2 || k == 3);
      step();
      if (rx_on_a && first < 0) first = k;
    end
    holdoff = 0;
    check("rx_lat_z5_hold2", first, 8);
    check("rx_mask", dbg_a[27:24], 4'hF);
    rx_online = 4'b1011;
    step();
    step();
    check("rx_drop", {rx_on_a, dbg_a[15:14]}, 0);

    // Asynchronous reset while in STB.
    tx_online = 0;
    step();
    dx = 3; dy = 5; tx_online = 1;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    step();
    step();
    #3 rst_n = 1'b1;
    tx_online = 0;
    step();
    tx_bringup(3, 5, "tx_lat_after_rst");

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
